// File: rtl/frame_rect_drawer.sv
`default_nettype none
// ============================================================================
// Module      : frame_rect_drawer
// Description : Command-driven drawing engine for the reduced-resolution frame
//               buffer write port. Draws filled rectangles, outline
//               rectangles, horizontal lines and vertical lines. Emits one
//               candidate pixel per cycle in row-major order and skips (and
//               flags) any pixel outside the buffer.
//               Optional macro FRAME_WR_READY_EN adds a wr_ready back-pressure
//               input that stalls the engine on unaccepted writes.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_rect_drawer #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int COORD_W   = 8,
  parameter int ADDR_W    = 15,
  parameter int COLOR_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  logic [COLOR_W-1:0] color,
`ifdef FRAME_WR_READY_EN
  input  logic               wr_ready,
`endif
  output logic               busy,
  output logic               done,
  output logic               clipped,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               wr_en
);

  // Pixel coordinates carry one extra bit so x0+cx / y0+cy never wrap.
  localparam int c_CW   = COORD_W + 1;
  // Row base must hold (y0 + cy) * FB_WIDTH without overflow.
  localparam int c_RB_W = COORD_W + $clog2(FB_WIDTH) + 1;

  localparam logic [1:0] c_MODE_FILL    = 2'd0;
  localparam logic [1:0] c_MODE_OUTLINE = 2'd1;
  localparam logic [1:0] c_MODE_HLINE   = 2'd2;
  localparam logic [1:0] c_MODE_VLINE   = 2'd3;

  localparam logic [c_CW-1:0]   c_FBW_X  = c_CW'(FB_WIDTH);
  localparam logic [c_CW-1:0]   c_FBH_Y  = c_CW'(FB_HEIGHT);
  localparam logic [c_RB_W-1:0] c_FBW_RB = c_RB_W'(FB_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched command
  logic [1:0]         r_mode;
  logic [COORD_W-1:0] r_x0;
  logic [COORD_W-1:0] r_y0;
  logic [COORD_W-1:0] r_w;
  logic [COORD_W-1:0] r_h;
  logic [COLOR_W-1:0] r_color;

  // Scan position of the candidate currently presented on the write port
  logic [COORD_W-1:0] r_cx;
  logic [COORD_W-1:0] r_cy;
  logic [c_RB_W-1:0]  r_rb;

  // Registered outputs
  logic               r_busy;
  logic               r_done;
  logic               r_clipped;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [COLOR_W-1:0] r_wr_data;
  logic               r_wr_en;

  // Next candidate and its evaluation
  logic [COORD_W-1:0] w_cand_cx;
  logic [COORD_W-1:0] w_cand_cy;
  logic [c_RB_W-1:0]  w_cand_rb;
  logic [c_CW-1:0]    w_px;
  logic [c_CW-1:0]    w_py;
  logic               w_in_bounds;
  logic               w_border;
  logic               w_needed;
  logic               w_cand_we;
  logic               w_cand_clip;
  logic [ADDR_W-1:0]  w_cand_addr;

  logic [c_RB_W-1:0]  w_rb0;
  logic [COORD_W-1:0] w_wm1;
  logic [COORD_W-1:0] w_hm1;
  logic               w_zero;
  logic               w_row_end;
  logic               w_last;
  logic               w_accept;

  assign w_rb0     = c_RB_W'(r_y0) * c_FBW_RB;
  assign w_wm1     = r_w - COORD_W'(1);
  assign w_hm1     = r_h - COORD_W'(1);
  assign w_zero    = (r_w == '0) || (r_h == '0);
  assign w_row_end = (r_cx == w_wm1);
  assign w_last    = w_row_end && (r_cy == w_hm1);

`ifdef FRAME_WR_READY_EN
  // An outstanding write must be accepted before the scan may move on.
  assign w_accept  = !r_wr_en || wr_ready;
`else
  assign w_accept  = 1'b1;
`endif

  // Candidate evaluation: bounds test, outline border test and address.
  assign w_px        = {1'b0, r_x0} + {1'b0, w_cand_cx};
  assign w_py        = {1'b0, r_y0} + {1'b0, w_cand_cy};
  assign w_in_bounds = (w_px < c_FBW_X) && (w_py < c_FBH_Y);
  assign w_border    = (w_cand_cx == '0) || (w_cand_cx == w_wm1) ||
                       (w_cand_cy == '0) || (w_cand_cy == w_hm1);
  assign w_needed    = (r_mode != c_MODE_OUTLINE) || w_border;
  assign w_cand_we   = w_needed && w_in_bounds;
  assign w_cand_clip = w_needed && !w_in_bounds;
  assign w_cand_addr = ADDR_W'(w_cand_rb + c_RB_W'(r_x0) + c_RB_W'(w_cand_cx));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and selection of the next candidate pixel.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_cx   = '0;
    w_cand_cy   = '0;
    w_cand_rb   = w_rb0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_nxt = w_zero ? ST_DONE : ST_DRAW;
      end
      ST_DRAW: begin
        w_cand_cx = r_cx;
        w_cand_cy = r_cy;
        w_cand_rb = r_rb;
        if (w_accept) begin
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else if (w_row_end) begin
            w_cand_cx = '0;
            w_cand_cy = r_cy + COORD_W'(1);
            w_cand_rb = r_rb + c_FBW_RB;
          end else begin
            w_cand_cx = r_cx + COORD_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch, scan counters and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= '0;
      r_x0      <= '0;
      r_y0      <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_color   <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_rb      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clipped <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done  <= 1'b0;
          r_wr_en <= 1'b0;
          if (start) begin
            r_mode    <= mode;
            r_x0      <= x0;
            r_y0      <= y0;
            r_w       <= (mode == c_MODE_VLINE) ? COORD_W'(1) : w;
            r_h       <= (mode == c_MODE_HLINE) ? COORD_W'(1) : h;
            r_color   <= color;
            r_busy    <= 1'b1;
            r_clipped <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (w_zero) begin
            r_done <= 1'b1;
          end else begin
            r_cx      <= '0;
            r_cy      <= '0;
            r_rb      <= w_rb0;
            r_wr_en   <= w_cand_we;
            r_wr_addr <= w_cand_addr;
            r_wr_data <= r_color;
            if (w_cand_clip) r_clipped <= 1'b1;
          end
        end
        ST_DRAW: begin
          if (w_accept) begin
            if (w_last) begin
              r_wr_en <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cx      <= w_cand_cx;
              r_cy      <= w_cand_cy;
              r_rb      <= w_cand_rb;
              r_wr_en   <= w_cand_we;
              r_wr_addr <= w_cand_addr;
              r_wr_data <= r_color;
              if (w_cand_clip) r_clipped <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_wr_en <= 1'b0;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign clipped = r_clipped;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign wr_en   = r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_frame_rect_drawer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_rect_drawer
// Description : Directed self-checking bench for frame_rect_drawer. Define
//               FRAME_WR_READY_EN to also exercise write back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_rect_drawer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  x0;
  logic [7:0]  y0;
  logic [7:0]  w;
  logic [7:0]  h;
  logic [23:0] color;
`ifdef FRAME_WR_READY_EN
  logic        wr_ready;
`endif
  logic        busy;
  logic        done;
  logic        clipped;
  logic [14:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_en;

  frame_rect_drawer #(
    .FB_WIDTH (160),
    .FB_HEIGHT(120),
    .COORD_W  (8),
    .ADDR_W   (15),
    .COLOR_W  (24)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .x0      (x0),
    .y0      (y0),
    .w       (w),
    .h       (h),
    .color   (color),
`ifdef FRAME_WR_READY_EN
    .wr_ready(wr_ready),
`endif
    .busy    (busy),
    .done    (done),
    .clipped (clipped),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Per-command observations gathered by run_cmd.
  int unsigned q_addr[$];
  int done_k;
  int done_cnt;
  int busy_cnt;
  int first_k;
  int data_bad;
  int hi_addr;
  int seen_161;
  int stall_bad;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Check the accepted write addresses against an expected list.
  task automatic chk_addrs(input string tag, input int unsigned exp[]);
    chk({tag, "_count"}, q_addr.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i),
          (i < q_addr.size()) ? q_addr[i] : 32'hFFFF_FFFF, exp[i]);
    end
  endtask

  // Issue one command and observe it until done (bounded). Cycle index k=1 is
  // the cycle right after the start edge. glitch_k pulses start mid-command;
  // stall_n holds wr_ready low on the second write for that many cycles.
  task automatic run_cmd(input logic [1:0] m, input logic [7:0] xx, input logic [7:0] yy,
                         input logic [7:0] ww, input logic [7:0] hh, input logic [23:0] col,
                         input int glitch_k, input int stall_n, input int unsigned stall_addr);
    int  stall_left;
    bit  seen_done;
    logic ready_now;
    q_addr.delete();
    done_k = 0; done_cnt = 0; busy_cnt = 0; first_k = 0;
    data_bad = 0; hi_addr = 0; seen_161 = 0; stall_bad = 0;
    stall_left = stall_n;
    @(posedge clk); #1;
    start = 1'b1; mode = m; x0 = xx; y0 = yy; w = ww; h = hh; color = col;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 1'b0;
    for (int k = 1; k <= 400 && !seen_done; k++) begin
      @(negedge clk);
      if (k == glitch_k) begin
        start = 1'b1; x0 = 8'd50; y0 = 8'd50; color = 24'h123456;
      end else begin
        start = 1'b0;
      end
      ready_now = 1'b1;
`ifdef FRAME_WR_READY_EN
      if (wr_en && q_addr.size() == 1 && stall_left > 0) begin
        wr_ready = 1'b0;
        if (wr_addr != stall_addr[14:0]) stall_bad++;
        stall_left--;
      end else begin
        wr_ready = 1'b1;
      end
      ready_now = wr_ready;
`endif
      if (wr_en && ready_now) begin
        q_addr.push_back(32'(wr_addr));
        if (first_k == 0) first_k = k;
        if (wr_data != col) data_bad++;
        if (wr_addr >= 15'd19200) hi_addr++;
        if (wr_addr == 15'd161) seen_161++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_k = k;
        seen_done = 1'b1;
      end
    end
    start = 1'b0;
    if (!seen_done) chk("timeout_done", 32'd0, 32'd1);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_single_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
`ifdef FRAME_WR_READY_EN
    wr_ready = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_clipped", 32'(clipped), 32'd0);
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;

    // Filled 3x2 rectangle at (10,2).
    run_cmd(2'd0, 8'd10, 8'd2, 8'd3, 8'd2, 24'h0000FF, 0, 0, 0);
    chk_addrs("fill", '{330, 331, 332, 490, 491, 492});
    chk("fill_done_cnt", done_cnt, 1);
    chk("fill_clipped",  32'(clipped), 32'd0);
    chk("fill_busy_cyc", busy_cnt, 8);
    chk("fill_first_wr", first_k, 2);
    chk("fill_data",     data_bad, 0);

    // Outline 3x3 at origin: centre 161 skipped, 9 candidate cycles.
    run_cmd(2'd1, 8'd0, 8'd0, 8'd3, 8'd3, 24'hA5A5A5, 0, 0, 0);
    chk_addrs("outline", '{0, 1, 2, 160, 162, 320, 321, 322});
    chk("outline_no161",  seen_161, 0);
    chk("outline_done_k", done_k, 11);
    chk("outline_clip",   32'(clipped), 32'd0);
    chk("outline_data",   data_bad, 0);

    // Horizontal line crossing the right edge on the last row.
    run_cmd(2'd2, 8'd158, 8'd119, 8'd4, 8'd5, 24'h00FF00, 0, 0, 0);
    chk_addrs("hline_clip", '{19198, 19199});
    chk("hline_hi_addr", hi_addr, 0);
    chk("hline_clipped", 32'(clipped), 32'd1);
    repeat (3) @(negedge clk);
    chk("hline_clip_hold", 32'(clipped), 32'd1);

    // Zero-size commands: no writes, done 2 cycles after start, clipped cleared.
    run_cmd(2'd3, 8'd5, 8'd5, 8'd7, 8'd0, 24'hFFFFFF, 0, 0, 0);
    chk("vline_h0_writes", q_addr.size(), 0);
    chk("vline_h0_done_k", done_k, 2);
    chk("vline_h0_clip",   32'(clipped), 32'd0);
    run_cmd(2'd0, 8'd5, 8'd5, 8'd0, 8'd4, 24'hFFFFFF, 0, 0, 0);
    chk("fill_w0_writes", q_addr.size(), 0);
    chk("fill_w0_done_k", done_k, 2);
    chk("fill_w0_clip",   32'(clipped), 32'd0);

    // Vertical line: width forced to 1 even though w=9.
    run_cmd(2'd3, 8'd7, 8'd118, 8'd9, 8'd3, 24'h0F0F0F, 0, 0, 0);
    chk_addrs("vline", '{18887, 19047});
    chk("vline_clipped", 32'(clipped), 32'd1);

    // Asynchronous reset in the middle of a clipping 10x10 fill.
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; x0 = 8'd155; y0 = 8'd0; w = 8'd10; h = 8'd10; color = 24'hC0FFEE;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_wr_en",   32'(wr_en),   32'd1);
    chk("mid_clipped", 32'(clipped), 32'd1);
    chk("mid_busy",    32'(busy),    32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",    32'(busy),    32'd0);
    chk("arst_wr_en",   32'(wr_en),   32'd0);
    chk("arst_wr_addr", 32'(wr_addr), 32'd0);
    chk("arst_wr_data", 32'(wr_data), 32'd0);
    chk("arst_clipped", 32'(clipped), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Normal run after reset, with a start pulse while busy that must be ignored.
    run_cmd(2'd0, 8'd10, 8'd2, 8'd3, 8'd2, 24'h0000FF, 4, 0, 0);
    chk_addrs("post_rst", '{330, 331, 332, 490, 491, 492});
    chk("post_rst_done_cnt", done_cnt, 1);
    chk("post_rst_data",     data_bad, 0);
    repeat (4) @(negedge clk);
    chk("ignored_start_busy", 32'(busy),  32'd0);
    chk("ignored_start_wr",   32'(wr_en), 32'd0);

`ifdef FRAME_WR_READY_EN
    // Back-pressure: second write of a 4-pixel hline held for 3 cycles.
    run_cmd(2'd2, 8'd20, 8'd5, 8'd4, 8'd1, 24'h00ABCD, 0, 3, 821);
    chk_addrs("stall", '{820, 821, 822, 823});
    chk("stall_hold",     stall_bad, 0);
    chk("stall_busy_cyc", busy_cnt, 9);
    chk("stall_data",     data_bad, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
